byte_packer: RTL and testbench

BYTE_PACKER -- requirements
Module: byte_packer

---
 rtl/byte_packer.sv | 110 +++++++++++
 tb/tb_byte_packer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// Packs a stream of bytes into BYTES_PER_WORD-byte words with selectable lane order.
// Define PACKER_PARTIAL_FLUSH_EN to emit a zero-padded partial word on sof instead of dropping it.
module byte_packer #(
  parameter int BYTES_PER_WORD = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        sof,
  input  logic                        msb_first,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3:0]                  out_bytes
);

  localparam int N  = BYTES_PER_WORD;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [8*N-1:0] acc_reg, acc_next;
  logic           order_reg, order_next;
  logic [8*N-1:0] out_data_reg, out_data_next;
  logic [3:0]     out_bytes_reg, out_bytes_next;
  logic           out_valid_reg, out_valid_next;

  logic           accept;
  logic           partial;
  logic [8*N-1:0] filled;
  logic [8*N-1:0] src;
  logic [8*N-1:0] src_rev;
  logic [8*N-1:0] emit_word;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign partial  = sof && (cnt_reg != '0);

  // Accumulator always holds lanes LSB-first; order is applied only when a word leaves.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign filled[8*gi +: 8]          = (cnt_reg == CW'(gi)) ? in_data : acc_reg[8*gi +: 8];
      assign src_rev[8*(N-1-gi) +: 8]   = src[8*gi +: 8];
    end
  endgenerate

  assign src       = partial ? acc_reg : filled;
  assign emit_word = order_reg ? src_rev : src;

  always_comb begin
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    order_next     = order_reg;
    out_data_next  = out_data_reg;
    out_bytes_next = out_bytes_reg;
    out_valid_next = out_valid_reg && !out_ready;
    if (accept) begin
      if (partial) begin
`ifdef PACKER_PARTIAL_FLUSH_EN
        out_data_next  = emit_word;
        out_bytes_next = 4'(cnt_reg);
        out_valid_next = 1'b1;
`endif
        acc_next   = {{(8*(N-1)){1'b0}}, in_data};
        cnt_next   = CW'(1);
        order_next = msb_first;
      end else begin
        if (cnt_reg == '0) begin
          order_next = msb_first;
        end
        if (cnt_reg == LAST) begin
          out_data_next  = emit_word;
          out_bytes_next = 4'(N);
          out_valid_next = 1'b1;
          acc_next       = '0;
          cnt_next       = '0;
        end else begin
          acc_next = filled;
          cnt_next = cnt_reg + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      acc_reg       <= '0;
      order_reg     <= 1'b0;
      out_data_reg  <= '0;
      out_bytes_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      order_reg     <= order_next;
      out_data_reg  <= out_data_next;
      out_bytes_reg <= out_bytes_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_bytes = out_bytes_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed scenarios plus randomized traffic
// against a queue-based model of the packing rules.
module tb_byte_packer;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     in_data = 8'h00;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           sof = 1'b0;
  logic           msb_first = 1'b0;
  logic [8*N-1:0] out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [3:0]     out_bytes;

  byte_packer #(.BYTES_PER_WORD(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sof(sof), .msb_first(msb_first), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bytes(out_bytes)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes of the word in progress, its order, and words waiting in the single output slot.
  logic [7:0]     cur[$];
  logic           cur_order = 1'b0;
  logic [8*N-1:0] exp_data[$];
  int             exp_bytes[$];
  int             words_seen = 0;

  function automatic logic [8*N-1:0] pack_word(input logic [7:0] b[$], input logic ord);
    logic [8*N-1:0] w = '0;
    for (int k = 0; k < b.size(); k++) begin
      int pos = ord ? (N - 1 - k) : k;
      w = w | ({{(8*(N-1)){1'b0}}, b[k]} << (8 * pos));
    end
    return w;
  endfunction

  task automatic model_accept(input logic [7:0] d, input logic s, input logic m);
    if (s && cur.size() > 0) begin
`ifdef PACKER_PARTIAL_FLUSH_EN
      exp_data.push_back(pack_word(cur, cur_order));
      exp_bytes.push_back(cur.size());
`endif
      cur.delete();
    end
    if (cur.size() == 0) cur_order = m;
    cur.push_back(d);
    if (cur.size() == N) begin
      exp_data.push_back(pack_word(cur, cur_order));
      exp_bytes.push_back(N);
      cur.delete();
    end
  endtask

  // Compare process: outputs sampled mid-cycle, then the model advances by the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_bytes", out_bytes, 0);
      check("rst_in_ready", in_ready, 1);
      cur.delete();
      exp_data.delete();
      exp_bytes.delete();
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      check("slot_depth", exp_data.size() <= 1, 1);
      check("out_valid", out_valid, exp_data.size() != 0);
      if (out_valid && exp_data.size() != 0) begin
        check("out_data", out_data, exp_data[0]);
        check("out_bytes", out_bytes, exp_bytes[0]);
      end
      if (out_valid && out_ready) begin
        words_seen++;
        if (exp_data.size() != 0) begin
          void'(exp_data.pop_front());
          void'(exp_bytes.pop_front());
        end
      end
      if (in_valid && in_ready) model_accept(in_data, sof, msb_first);
    end
  end

  // Drive one byte and return just after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic s, input logic m);
    int t = 0;
    in_data = d; sof = s; msb_first = m; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 100) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 8'($urandom); sof = 1'($urandom); msb_first = 1'($urandom);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  time t0;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("ready_after_rst", in_ready, 1);

    // LSB-first word, back-to-back, visible at the third byte's edge for one cycle
    out_ready = 1'b1;
    send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0);
    check("lsb_valid", out_valid, 1);
    check("lsb_data", out_data, 24'h332211);
    check("lsb_bytes", out_bytes, 3);
    tick();
    check("lsb_one_cycle", out_valid, 0);

    // MSB-first latched on lane 0; toggling later has no effect
    send(8'h11, 0, 1); send(8'h22, 0, 0); send(8'h33, 0, 0);
    check("msb_data", out_data, 24'h112233);
    tick();

    // Back-pressure holds the word, then streaming resumes without bubbles
    out_ready = 1'b0;
    send(8'h44, 0, 0); send(8'h55, 0, 0); send(8'h66, 0, 0);
    repeat (3) tick();
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_data", out_data, 24'h665544);
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    t0 = $time;
    send(8'h77, 0, 0); send(8'h88, 0, 0); send(8'h99, 0, 0);
    check("stream_cycles", ($time - t0) / 10, 3);
    check("stream_data", out_data, 24'h998877);
    tick();

    // sof mid-word
    send(8'hAA, 0, 0); send(8'hBB, 0, 0); send(8'hCC, 1, 0);
`ifdef PACKER_PARTIAL_FLUSH_EN
    check("flush_valid", out_valid, 1);
    check("flush_data", out_data, 24'h00BBAA);
    check("flush_bytes", out_bytes, 2);
`else
    check("discard_valid", out_valid, 0);
`endif
    send(8'hDD, 0, 0); send(8'hEE, 0, 0);
    check("sof_word_data", out_data, 24'hEEDDCC);
    check("sof_word_bytes", out_bytes, 3);
    tick();

    // Reset mid-word drops the partial byte
    send(8'h5A, 0, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_ready", in_ready, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0);
    check("post_rst_data", out_data, 24'h030201);
    tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      sof       = ($urandom % 7) == 0;
      msb_first = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      rst_n     = ($urandom % 600) != 0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    repeat (4) tick();
    check("drained", exp_data.size(), 0);
    check("words_seen_nonzero", words_seen > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
